// File: rtl/alu_ctrl_pkg.sv
// rtl/alu_ctrl_pkg.sv - shared state encoding, opcodes and ALU widths for the ALU op scheduler
package alu_ctrl_pkg;

    localparam int ALU_DATA_W = 5;
    localparam int ALU_OP_W   = 3;
    localparam int ALU_RES_W  = 32;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        CAPTURE = 2'd2,
        RESP    = 2'd3
    } state_t;

    localparam logic [ALU_OP_W-1:0] OP_XOR = 3'd0;
    localparam logic [ALU_OP_W-1:0] OP_AND = 3'd1;
    localparam logic [ALU_OP_W-1:0] OP_OR  = 3'd2;
    localparam logic [ALU_OP_W-1:0] OP_ADD = 3'd3;
    localparam logic [ALU_OP_W-1:0] OP_SUB = 3'd4;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin arbiter, search starts one above the pointer
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    pointer,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    index,
    output logic               found
);

    logic [ID_W-1:0] idx;

    always_comb begin
        grant = '0;
        index = '0;
        found = 1'b0;
        idx   = '0;
        // Last candidate examined is the pointer itself, so a lone requester always wins.
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = ID_W'((int'(pointer) + k) % NUM_REQ);
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                index      = idx;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_op_scheduler.sv
// rtl/alu_op_scheduler.sv - shares one registered ALU among NUM_REQ requesters, one op in flight
module alu_op_scheduler
    import alu_ctrl_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int ID_W        = 2,
    parameter int DATA_W      = ALU_DATA_W,
    parameter int OP_W        = ALU_OP_W,
    parameter int RES_W       = ALU_RES_W,
    parameter int ALU_LATENCY = 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*DATA_W-1:0] req_number1,
    input  logic [NUM_REQ*DATA_W-1:0] req_number2,
    input  logic [NUM_REQ*OP_W-1:0]   req_op,
    output logic [DATA_W-1:0]         alu_number1,
    output logic [DATA_W-1:0]         alu_number2,
    output logic [OP_W-1:0]           alu_op,
    input  logic [RES_W-1:0]          alu_result,
    input  logic                      alu_balance,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [ID_W-1:0]           rsp_id,
    output logic [RES_W-1:0]          rsp_result,
    output logic                      rsp_balance,
    output logic                      busy
);

    localparam int CNT_W = (ALU_LATENCY < 1) ? 1 : $clog2(ALU_LATENCY + 1);

    if (ALU_LATENCY < 1) begin : g_bad_latency
        $error("alu_op_scheduler: ALU_LATENCY must be at least 1");
    end

    state_t             state;
    state_t             state_next;
    logic [ID_W-1:0]    ptr;
    logic [ID_W-1:0]    cur_id;
    logic [CNT_W-1:0]   cnt;
    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]    grant_idx;
    logic               grant_found;

    logic [DATA_W-1:0] num1_arr [NUM_REQ];
    logic [DATA_W-1:0] num2_arr [NUM_REQ];
    logic [OP_W-1:0]   op_arr   [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign num1_arr[i] = req_number1[i*DATA_W +: DATA_W];
        assign num2_arr[i] = req_number2[i*DATA_W +: DATA_W];
        assign op_arr[i]   = req_op[i*OP_W +: OP_W];
    end

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_arb (
        .req     (req_valid),
        .pointer (ptr),
        .grant   (grant),
        .index   (grant_idx),
        .found   (grant_found)
    );

    always_comb begin
        state_next = state;
        req_ready  = '0;
        case (state)
            IDLE: begin
                req_ready = grant;
                if (grant_found) state_next = WAIT;
            end
            WAIT:    if (cnt == CNT_W'(1)) state_next = CAPTURE;
            CAPTURE: state_next = RESP;
            RESP:    if (rsp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            ptr         <= ID_W'(NUM_REQ - 1);
            cur_id      <= '0;
            cnt         <= '0;
            alu_number1 <= '0;
            alu_number2 <= '0;
            alu_op      <= '0;
            rsp_valid   <= 1'b0;
            rsp_id      <= '0;
            rsp_result  <= '0;
            rsp_balance <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (grant_found) begin
                        alu_number1 <= num1_arr[grant_idx];
                        alu_number2 <= num2_arr[grant_idx];
                        alu_op      <= op_arr[grant_idx];
                        cur_id      <= grant_idx;
                        ptr         <= grant_idx;
                        cnt         <= CNT_W'(ALU_LATENCY);
                    end
                end
                WAIT: cnt <= cnt - CNT_W'(1);
                CAPTURE: begin
                    rsp_result  <= alu_result;
                    rsp_balance <= alu_balance;
                    rsp_id      <= cur_id;
                    rsp_valid   <= 1'b1;
                end
                RESP: if (rsp_ready) rsp_valid <= 1'b0;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_op_scheduler.sv
// tb/tb_alu_op_scheduler.sv - directed self-checking bench with a registered-XOR ALU model
module tb_alu_op_scheduler;
    import alu_ctrl_pkg::*;

    logic        clk;
    logic        reset;
    int          n_cmp;
    int          n_bad;

    logic [3:0]  req_valid, req_ready;
    logic [19:0] req_number1, req_number2;
    logic [11:0] req_op;
    logic [4:0]  alu_number1, alu_number2;
    logic [2:0]  alu_op;
    logic [31:0] alu_result, rsp_result;
    logic        alu_balance, rsp_valid, rsp_ready, rsp_balance, busy;
    logic [1:0]  rsp_id;

    logic [3:0]  req_valid3, req_ready3;
    logic [19:0] req_number1_3, req_number2_3;
    logic [11:0] req_op3;
    logic [4:0]  alu_number1_3, alu_number2_3;
    logic [2:0]  alu_op3;
    logic [31:0] alu_result3, rsp_result3;
    logic        alu_balance3, rsp_valid3, rsp_ready3, rsp_balance3, busy3;
    logic [1:0]  rsp_id3;

    logic [31:0] p_res [3];
    logic        p_bal [3];

    alu_op_scheduler #(.ALU_LATENCY(1)) u_dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_number1(req_number1), .req_number2(req_number2), .req_op(req_op),
        .alu_number1(alu_number1), .alu_number2(alu_number2), .alu_op(alu_op),
        .alu_result(alu_result), .alu_balance(alu_balance),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_result(rsp_result), .rsp_balance(rsp_balance), .busy(busy)
    );

    alu_op_scheduler #(.ALU_LATENCY(3)) u_dut3 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid3), .req_ready(req_ready3),
        .req_number1(req_number1_3), .req_number2(req_number2_3), .req_op(req_op3),
        .alu_number1(alu_number1_3), .alu_number2(alu_number2_3), .alu_op(alu_op3),
        .alu_result(alu_result3), .alu_balance(alu_balance3),
        .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready3), .rsp_id(rsp_id3),
        .rsp_result(rsp_result3), .rsp_balance(rsp_balance3), .busy(busy3)
    );

    function automatic logic [31:0] sext5(input logic [4:0] v);
        return {{27{v[4]}}, v};
    endfunction

    // ALU models: XOR of the operands, result sign-extended from bit 4, balance = even popcount.
    always_ff @(posedge clk) begin
        alu_result  <= sext5(alu_number1 ^ alu_number2);
        alu_balance <= ~^(alu_number1 ^ alu_number2);
        p_res[0]    <= sext5(alu_number1_3 ^ alu_number2_3);
        p_bal[0]    <= ~^(alu_number1_3 ^ alu_number2_3);
        p_res[1]    <= p_res[0];
        p_bal[1]    <= p_bal[0];
        p_res[2]    <= p_res[1];
        p_bal[2]    <= p_bal[1];
    end
    assign alu_result3  = p_res[2];
    assign alu_balance3 = p_bal[2];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset      = 1'b1;
        req_valid  = '0;
        req_valid3 = '0;
        rsp_ready  = 1'b0;
        rsp_ready3 = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++;
        if ({rsp_valid, busy, rsp_id, rsp_result, rsp_balance} !== 37'd0) begin
            n_bad++;
            $display("FAIL reset_rsp got v=%b busy=%b id=%0d res=%h bal=%b expected all zero",
                     rsp_valid, busy, rsp_id, rsp_result, rsp_balance);
        end
        n_cmp++;
        if ({alu_number1, alu_number2, alu_op, req_ready} !== 17'd0) begin
            n_bad++;
            $display("FAIL reset_alu got n1=%0d n2=%0d op=%0d rdy=%b expected all zero",
                     alu_number1, alu_number2, alu_op, req_ready);
        end
        n_cmp++;
        if ({rsp_valid3, busy3, alu_number1_3} !== 7'd0) begin
            n_bad++;
            $display("FAIL reset_dut3 got v=%b busy=%b n1=%0d expected zero", rsp_valid3, busy3, alu_number1_3);
        end
        req_valid = 4'b1111;
        #1;
        n_cmp++;
        if (req_ready !== 4'b0001) begin
            n_bad++;
            $display("FAIL reset_priority got %b expected 0001", req_ready);
        end
        req_valid = '0;
        #1;
    endtask

    task automatic test_single_and_hold();
        do_reset();
        req_number1 = {5'd0, 5'd0, 5'd0, 5'd21};
        req_number2 = {5'd0, 5'd0, 5'd0, 5'd10};
        req_op      = {OP_XOR, OP_XOR, OP_XOR, OP_XOR};
        req_valid   = 4'b0001;
        #1;
        n_cmp++;
        if (req_ready !== 4'b0001) begin
            n_bad++;
            $display("FAIL single_ready got %b expected 0001", req_ready);
        end
        tick();
        req_valid = '0;
        n_cmp++;
        if ({busy, alu_number1, alu_number2, alu_op} !== {1'b1, 5'd21, 5'd10, OP_XOR}) begin
            n_bad++;
            $display("FAIL single_alu got busy=%b n1=%0d n2=%0d op=%0d expected 1/21/10/0",
                     busy, alu_number1, alu_number2, alu_op);
        end
        tick();
        n_cmp++;
        if (rsp_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL single_early got rsp_valid=%b expected 0", rsp_valid);
        end
        tick();
        n_cmp++;
        if ({rsp_valid, rsp_id, rsp_result, rsp_balance} !== {1'b1, 2'd0, 32'hFFFF_FFFF, 1'b0}) begin
            n_bad++;
            $display("FAIL single_rsp got v=%b id=%0d res=%h bal=%b expected 1/0/ffffffff/0",
                     rsp_valid, rsp_id, rsp_result, rsp_balance);
        end
        // Hold response with rsp_ready low while all requesters clamour.
        req_valid = 4'b1111;
        for (int c = 0; c < 5; c++) begin
            tick();
            n_cmp++;
            if ({rsp_valid, rsp_id, rsp_result, rsp_balance, req_ready} !==
                {1'b1, 2'd0, 32'hFFFF_FFFF, 1'b0, 4'b0000}) begin
                n_bad++;
                $display("FAIL hold_cycle%0d got v=%b id=%0d res=%h bal=%b rdy=%b expected 1/0/ffffffff/0/0000",
                         c, rsp_valid, rsp_id, rsp_result, rsp_balance, req_ready);
            end
        end
        req_valid = '0;
        rsp_ready = 1'b1;
        tick();
        n_cmp++;
        if ({rsp_valid, busy} !== 2'b00) begin
            n_bad++;
            $display("FAIL hold_release got v=%b busy=%b expected 0/0", rsp_valid, busy);
        end
    endtask

    task automatic test_back_to_back();
        logic [4:0]  n1_t  [4];
        logic [4:0]  n2_t  [4];
        logic [2:0]  op_t  [4];
        logic [31:0] res_t [4];
        logic        bal_t [4];
        n1_t  = '{5'd1, 5'd6, 5'd12, 5'd31};
        n2_t  = '{5'd2, 5'd6, 5'd2, 5'd15};
        op_t  = '{OP_AND, OP_OR, OP_ADD, OP_SUB};
        res_t = '{32'h0000_0003, 32'h0000_0000, 32'h0000_000E, 32'hFFFF_FFF0};
        bal_t = '{1'b1, 1'b1, 1'b0, 1'b0};
        do_reset();
        req_number1 = {n1_t[3], n1_t[2], n1_t[1], n1_t[0]};
        req_number2 = {n2_t[3], n2_t[2], n2_t[1], n2_t[0]};
        req_op      = {op_t[3], op_t[2], op_t[1], op_t[0]};
        req_valid   = 4'b1111;
        rsp_ready   = 1'b1;
        #1;
        for (int g = 0; g < 4; g++) begin
            n_cmp++;
            if (req_ready !== 4'(1 << g)) begin
                n_bad++;
                $display("FAIL b2b_grant%0d got %b expected %b", g, req_ready, 4'(1 << g));
            end
            tick();
            req_valid[g] = 1'b0;
            n_cmp++;
            if ({alu_number1, alu_number2, alu_op} !== {n1_t[g], n2_t[g], op_t[g]}) begin
                n_bad++;
                $display("FAIL b2b_alu%0d got n1=%0d n2=%0d op=%0d expected %0d/%0d/%0d",
                         g, alu_number1, alu_number2, alu_op, n1_t[g], n2_t[g], op_t[g]);
            end
            tick();
            n_cmp++;
            if (req_ready !== 4'b0000) begin
                n_bad++;
                $display("FAIL b2b_busy_ready%0d got %b expected 0000", g, req_ready);
            end
            tick();
            n_cmp++;
            if ({rsp_valid, rsp_id, rsp_result, rsp_balance} !== {1'b1, 2'(g), res_t[g], bal_t[g]}) begin
                n_bad++;
                $display("FAIL b2b_rsp%0d got v=%b id=%0d res=%h bal=%b expected 1/%0d/%h/%b",
                         g, rsp_valid, rsp_id, rsp_result, rsp_balance, g, res_t[g], bal_t[g]);
            end
            tick();
        end
        n_cmp++;
        if ({rsp_valid, busy} !== 2'b00) begin
            n_bad++;
            $display("FAIL b2b_end got v=%b busy=%b expected 0/0", rsp_valid, busy);
        end
    endtask

    task automatic test_alternate();
        logic [3:0] exp_g;
        do_reset();
        req_number1 = '0;
        req_number2 = '0;
        req_op      = '0;
        req_valid   = 4'b0110;
        rsp_ready   = 1'b1;
        #1;
        for (int j = 0; j < 4; j++) begin
            exp_g = (j % 2 == 0) ? 4'b0010 : 4'b0100;
            n_cmp++;
            if (req_ready !== exp_g) begin
                n_bad++;
                $display("FAIL alt_grant%0d got %b expected %b", j, req_ready, exp_g);
            end
            tick();
            tick();
            tick();
            n_cmp++;
            if ({rsp_valid, rsp_id} !== {1'b1, (j % 2 == 0) ? 2'd1 : 2'd2}) begin
                n_bad++;
                $display("FAIL alt_rsp%0d got v=%b id=%0d expected 1/%0d",
                         j, rsp_valid, rsp_id, (j % 2 == 0) ? 1 : 2);
            end
            tick();
        end
        req_valid = '0;
    endtask

    task automatic test_reset_in_wait();
        do_reset();
        req_number1 = {5'd0, 5'd9, 5'd0, 5'd4};
        req_number2 = '0;
        req_op      = '0;
        req_valid   = 4'b0001;
        tick();
        req_valid = '0;
        reset     = 1'b1;
        tick();
        reset = 1'b0;
        n_cmp++;
        if ({rsp_valid, busy} !== 2'b00) begin
            n_bad++;
            $display("FAIL rstwait_abort got v=%b busy=%b expected 0/0", rsp_valid, busy);
        end
        tick();
        tick();
        n_cmp++;
        if (rsp_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL rstwait_norsp got v=%b expected 0", rsp_valid);
        end
        req_valid = 4'b0101;
        #1;
        n_cmp++;
        if (req_ready !== 4'b0001) begin
            n_bad++;
            $display("FAIL rstwait_ptr got %b expected 0001", req_ready);
        end
        req_valid = '0;
        #1;
    endtask

    task automatic test_latency3();
        logic exp_v;
        do_reset();
        req_number1_3 = {5'd0, 5'd0, 5'd0, 5'd3};
        req_number2_3 = {5'd0, 5'd0, 5'd0, 5'd5};
        req_op3       = '0;
        req_valid3    = 4'b0001;
        #1;
        n_cmp++;
        if (req_ready3 !== 4'b0001) begin
            n_bad++;
            $display("FAIL lat3_ready got %b expected 0001", req_ready3);
        end
        tick();
        req_valid3 = '0;
        for (int k = 1; k <= 4; k++) begin
            tick();
            exp_v = (k == 4);
            n_cmp++;
            if (rsp_valid3 !== exp_v) begin
                n_bad++;
                $display("FAIL lat3_valid_T+%0d got %b expected %b", k + 1, rsp_valid3, exp_v);
            end
        end
        n_cmp++;
        if ({rsp_id3, rsp_result3, rsp_balance3} !== {2'd0, 32'd6, 1'b1}) begin
            n_bad++;
            $display("FAIL lat3_rsp got id=%0d res=%h bal=%b expected 0/00000006/1",
                     rsp_id3, rsp_result3, rsp_balance3);
        end
        rsp_ready3 = 1'b1;
        tick();
        n_cmp++;
        if ({rsp_valid3, busy3} !== 2'b00) begin
            n_bad++;
            $display("FAIL lat3_done got v=%b busy=%b expected 0/0", rsp_valid3, busy3);
        end
    endtask

    initial begin
        n_cmp         = 0;
        n_bad         = 0;
        reset         = 1'b1;
        req_valid     = '0;
        req_number1   = '0;
        req_number2   = '0;
        req_op        = '0;
        rsp_ready     = 1'b0;
        req_valid3    = '0;
        req_number1_3 = '0;
        req_number2_3 = '0;
        req_op3       = '0;
        rsp_ready3    = 1'b0;
        test_reset();
        test_single_and_hold();
        test_back_to_back();
        test_alternate();
        test_reset_in_wait();
        test_latency3();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
